// File: rtl/one_wire_pkg.sv
`default_nettype none
// ============================================================================
// Module  : one_wire_pkg
// Purpose : Shared constants, state encodings and helpers for the 1-wire
//           transaction sequencer and its header shifter.
// Revision: 1.0 - initial release
// ============================================================================
package one_wire_pkg;

    // Operations understood by the byte-level bus master
    localparam logic [1:0] BM_OP_RESET = 2'b00;
    localparam logic [1:0] BM_OP_WRITE = 2'b01;
    localparam logic [1:0] BM_OP_READ  = 2'b10;

    localparam int MAX_LEN    = 32;
    localparam int HDR_DEPTH  = 12;

    localparam logic [7:0] MATCH_ROM = 8'h55;
    localparam logic [7:0] SKIP_ROM  = 8'hCC;

    typedef logic [HDR_DEPTH-1:0][7:0] hdr_bytes_t;

    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_LATCH       = 4'd1;
    localparam logic [3:0] ST_BUS_RST     = 4'd2;
    localparam logic [3:0] ST_WAIT_RST    = 4'd3;
    localparam logic [3:0] ST_HDR_SEND    = 4'd4;
    localparam logic [3:0] ST_HDR_WAIT    = 4'd5;
    localparam logic [3:0] ST_PAYLOAD_SEL = 4'd6;
    localparam logic [3:0] ST_FETCH       = 4'd7;
    localparam logic [3:0] ST_WR_SEND     = 4'd8;
    localparam logic [3:0] ST_WR_WAIT     = 4'd9;
    localparam logic [3:0] ST_RD_REQ      = 4'd10;
    localparam logic [3:0] ST_RD_WAIT     = 4'd11;
    localparam logic [3:0] ST_DONE        = 4'd12;
    localparam logic [3:0] ST_ERROR       = 4'd13;

    // States that launch a bus-master operation for exactly one cycle
    function automatic logic is_req_state(input logic [3:0] st);
        return (st == ST_BUS_RST) || (st == ST_HDR_SEND) ||
               (st == ST_WR_SEND) || (st == ST_RD_REQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/one_wire_hdr_shift.sv
`default_nettype none
// ============================================================================
// Module  : one_wire_hdr_shift
// Purpose : Parallel-load header byte shifter with remaining-byte count.
// Revision: 1.0 - initial release
// ============================================================================
module one_wire_hdr_shift
    import one_wire_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  hdr_bytes_t       bytes_i,
    input  logic [3:0]       count_i,
    input  logic             shift_i,
    output logic [7:0]       head_o,
    output logic             empty_o,
    output logic             last_o
);

    hdr_bytes_t bytes_q;
    logic [3:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bytes_q <= '0;
            cnt_q   <= 4'd0;
        end else if (load_i) begin
            bytes_q <= bytes_i;
            cnt_q   <= count_i;
        end else if (shift_i && (cnt_q != 4'd0)) begin
            bytes_q <= {8'h00, bytes_q[HDR_DEPTH-1:1]};
            cnt_q   <= cnt_q - 4'd1;
        end
    end

    assign head_o  = bytes_q[0];
    assign empty_o = (cnt_q == 4'd0);
    assign last_o  = (cnt_q == 4'd1);

endmodule
`default_nettype wire

// File: rtl/one_wire_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : one_wire_txn_sequencer
// Purpose : Runs one 1-wire transaction (reset, ROM/ID, function, address,
//           payload) by issuing byte ops to the bus master.
// Revision: 1.0 - initial release
// ============================================================================
module one_wire_txn_sequencer #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int UID_WIDTH     = 56,
    parameter int MAX_LEN       = one_wire_pkg::MAX_LEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     read_match,
    input  logic                     read_write,
    input  logic [7:0]               rom_cmd,
    input  logic [UID_WIDTH-1:0]     uid_data,
    input  logic [7:0]               uid_crc,
    input  logic [7:0]               fun_cmd,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [5:0]               data_length,
    output logic [4:0]               bram_addr,
    input  logic [7:0]               bram_rd_data,
    output logic                     bram_wr_en,
    output logic [7:0]               bram_wr_data,
    output logic                     bm_req,
    output logic [1:0]               bm_op,
    output logic [7:0]               bm_tx_byte,
    input  logic                     bm_done,
    input  logic                     bm_presence,
    input  logic [7:0]               bm_rx_byte,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);
    import one_wire_pkg::*;

    localparam logic [6:0] C_MAX_LEN = 7'(MAX_LEN);

    logic [3:0]               state_q, state_d;
    logic [5:0]               idx_q, idx_d;
    logic [7:0]               tx_q, tx_d;
    logic                     rm_q, rw_q;
    logic [7:0]               rom_q, crc_q, fun_q;
    logic [UID_WIDTH-1:0]     uid_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [5:0]               len_q;

    hdr_bytes_t               hdr_bytes;
    logic                     hdr_load, hdr_shift, hdr_empty, hdr_last;
    logic [7:0]               hdr_head;
    logic [5:0]               idx_next;

    assign idx_next = idx_q + 6'd1;

    // MATCH-ROM path carries the 7 ID bytes (LSB first) and CRC between ROM and function command
    always_comb begin
        hdr_bytes    = '0;
        hdr_bytes[0] = rom_q;
        if (rm_q) begin
            for (int i = 0; i < 7; i++) begin
                hdr_bytes[i+1] = uid_q[8*i +: 8];
            end
            hdr_bytes[8]  = crc_q;
            hdr_bytes[9]  = fun_q;
            hdr_bytes[10] = addr_q[7:0];
            hdr_bytes[11] = addr_q[15:8];
        end else begin
            hdr_bytes[1] = fun_q;
            hdr_bytes[2] = addr_q[7:0];
            hdr_bytes[3] = addr_q[15:8];
        end
    end

    one_wire_hdr_shift u_hdr_shift (
        .clk     (clk),
        .reset   (reset),
        .load_i  (hdr_load),
        .bytes_i (hdr_bytes),
        .count_i (rm_q ? 4'd12 : 4'd4),
        .shift_i (hdr_shift),
        .head_o  (hdr_head),
        .empty_o (hdr_empty),
        .last_o  (hdr_last)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        hdr_load  = 1'b0;
        hdr_shift = 1'b0;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_LATCH;
            ST_LATCH: begin
                if ({1'b0, len_q} > C_MAX_LEN) begin
                    state_d = ST_ERROR;
                end else begin
                    hdr_load = 1'b1;
                    idx_d    = 6'd0;
                    state_d  = ST_BUS_RST;
                end
            end
            ST_BUS_RST:  state_d = ST_WAIT_RST;
            ST_WAIT_RST: if (bm_done) state_d = bm_presence ? ST_HDR_SEND : ST_ERROR;
            ST_HDR_SEND: state_d = ST_HDR_WAIT;
            ST_HDR_WAIT: begin
                if (bm_done) begin
                    hdr_shift = 1'b1;
                    state_d   = (hdr_last || hdr_empty) ? ST_PAYLOAD_SEL : ST_HDR_SEND;
                end
            end
            ST_PAYLOAD_SEL: begin
                if (len_q == 6'd0)  state_d = ST_DONE;
                else if (rw_q)      state_d = ST_FETCH;
                else                state_d = ST_RD_REQ;
            end
            // FETCH gives the synchronous BRAM one cycle to present idx's byte
            ST_FETCH:    state_d = ST_WR_SEND;
            ST_WR_SEND: begin
                tx_d    = bram_rd_data;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (bm_done) begin
                    idx_d   = idx_next;
                    state_d = (idx_next == len_q) ? ST_DONE : ST_FETCH;
                end
            end
            ST_RD_REQ:   state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (bm_done) begin
                    idx_d   = idx_next;
                    state_d = (idx_next == len_q) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_DONE, ST_ERROR: begin
                idx_d   = 6'd0;
                state_d = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 6'd0;
            tx_q    <= 8'h00;
            rm_q    <= 1'b0;
            rw_q    <= 1'b0;
            rom_q   <= 8'h00;
            uid_q   <= '0;
            crc_q   <= 8'h00;
            fun_q   <= 8'h00;
            addr_q  <= '0;
            len_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            if ((state_q == ST_IDLE) && start) begin
                rm_q   <= read_match;
                rw_q   <= read_write;
                rom_q  <= rom_cmd;
                uid_q  <= uid_data;
                crc_q  <= uid_crc;
                fun_q  <= fun_cmd;
                addr_q <= address;
                len_q  <= data_length;
            end
        end
    end

    always_comb begin
        bm_op = BM_OP_RESET;
        case (state_q)
            ST_HDR_SEND, ST_HDR_WAIT, ST_WR_SEND, ST_WR_WAIT: bm_op = BM_OP_WRITE;
            ST_RD_REQ, ST_RD_WAIT:                            bm_op = BM_OP_READ;
            default:                                          bm_op = BM_OP_RESET;
        endcase
    end

    // tx byte stays frozen from request to completion: header head only shifts on bm_done
    always_comb begin
        bm_tx_byte = 8'h00;
        case (state_q)
            ST_HDR_SEND, ST_HDR_WAIT: bm_tx_byte = hdr_head;
            ST_WR_SEND:               bm_tx_byte = bram_rd_data;
            ST_WR_WAIT:               bm_tx_byte = tx_q;
            default:                  bm_tx_byte = 8'h00;
        endcase
    end

    assign bm_req       = is_req_state(state_q);
    assign bram_addr    = idx_q[4:0];
    assign bram_wr_en   = (state_q == ST_RD_WAIT) && bm_done;
    assign bram_wr_data = bram_wr_en ? bm_rx_byte : 8'h00;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign error        = (state_q == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_one_wire_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_one_wire_txn_sequencer
// Purpose : Directed self-checking bench with a bus-master and BRAM model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_one_wire_txn_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        read_match = 1'b0;
    logic        read_write = 1'b0;
    logic [7:0]  rom_cmd = 8'h00;
    logic [55:0] uid_data = '0;
    logic [7:0]  uid_crc = 8'h00;
    logic [7:0]  fun_cmd = 8'h00;
    logic [15:0] address = 16'h0000;
    logic [5:0]  data_length = 6'd0;
    logic [4:0]  bram_addr;
    logic [7:0]  bram_rd_data;
    logic        bram_wr_en;
    logic [7:0]  bram_wr_data;
    logic        bm_req;
    logic [1:0]  bm_op;
    logic [7:0]  bm_tx_byte;
    logic        bm_done = 1'b0;
    logic        bm_presence = 1'b0;
    logic [7:0]  bm_rx_byte = 8'h00;
    logic        busy, done, error;

    always #5 clk = ~clk;

    one_wire_txn_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .read_match(read_match),
        .read_write(read_write), .rom_cmd(rom_cmd), .uid_data(uid_data),
        .uid_crc(uid_crc), .fun_cmd(fun_cmd), .address(address),
        .data_length(data_length), .bram_addr(bram_addr),
        .bram_rd_data(bram_rd_data), .bram_wr_en(bram_wr_en),
        .bram_wr_data(bram_wr_data), .bm_req(bm_req), .bm_op(bm_op),
        .bm_tx_byte(bm_tx_byte), .bm_done(bm_done), .bm_presence(bm_presence),
        .bm_rx_byte(bm_rx_byte), .busy(busy), .done(done), .error(error)
    );

    // Synchronous BRAM with a bench-side preload port
    logic [7:0] mem [32];
    logic       tb_we = 1'b0;
    logic [4:0] tb_wa = 5'd0;
    logic [7:0] tb_wd = 8'h00;
    always @(posedge clk) begin
        bram_rd_data <= mem[bram_addr];
        if (tb_we)           mem[tb_wa]     <= tb_wd;
        else if (bram_wr_en) mem[bram_addr] <= bram_wr_data;
    end

    // Bus-master model: logs each op as {op, write byte}, answers after 3 cycles
    logic [9:0] op_log [$];
    logic [7:0] rx_tab [4];
    logic       pres_cfg = 1'b1;
    int         rd_cnt = 0, rd_base = 0;
    int         done_cnt = 0, err_cnt = 0;
    int         overlap_err = 0, stable_err = 0;
    logic       outstanding = 1'b0;
    int         dly = 0;
    logic [1:0] cur_op = 2'b00;
    logic [7:0] cur_tx = 8'h00;

    always @(negedge clk) begin
        bm_done = 1'b0;
        if (reset) begin
            outstanding = 1'b0;
        end else begin
            if (done)  done_cnt++;
            if (error) err_cnt++;
            if (outstanding) begin
                if (bm_req) overlap_err++;
                if (dly == 0) begin
                    bm_done     = 1'b1;
                    bm_presence = pres_cfg;
                    bm_rx_byte  = 8'h00;
                    if (cur_op == 2'b10) begin
                        bm_rx_byte = rx_tab[(rd_cnt - rd_base) & 3];
                        rd_cnt++;
                    end
                    if (bm_tx_byte !== cur_tx) stable_err++;
                    outstanding = 1'b0;
                end else begin
                    dly--;
                end
            end else if (bm_req) begin
                outstanding = 1'b1;
                dly         = 2;
                cur_op      = bm_op;
                cur_tx      = bm_tx_byte;
                op_log.push_back({bm_op, (bm_op == 2'b01) ? bm_tx_byte : 8'h00});
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [9:0] exp1 [16] = '{10'h000, 10'h155, 10'h166, 10'h155, 10'h144, 10'h133,
                              10'h122, 10'h111, 10'h100, 10'h1A5, 10'h10F, 10'h134,
                              10'h112, 10'h111, 10'h122, 10'h133};
    logic [9:0] exp2 [16] = '{10'h000, 10'h1CC, 10'h1F0, 10'h110, 10'h100, 10'h200,
                              10'h200, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000,
                              10'h000, 10'h000, 10'h000, 10'h000};

    task automatic chk_ops(input string tag, input int base, input int n, input logic [9:0] e [16]);
        chk({tag, "_nops"}, op_log.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < op_log.size())
                chk($sformatf("%s_op%0d", tag, i), {22'd0, op_log[base+i]}, {22'd0, e[i]});
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic set_cmd(input logic rm, input logic rw, input logic [7:0] rom,
                           input logic [55:0] uid, input logic [7:0] crc, input logic [7:0] fun,
                           input logic [15:0] addr, input logic [5:0] len);
        read_match = rm; read_write = rw; rom_cmd = rom; uid_data = uid;
        uid_crc = crc; fun_cmd = fun; address = addr; data_length = len;
    endtask

    // Pulse start and wait for busy to drop; optionally re-pulse start mid-run
    task automatic run_wait(input string tag, input int inj);
        bit finished = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 3000; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (inj > 0 && i == inj) begin
                start = 1'b1;
                set_cmd(1'b1, 1'b1, 8'h00, 56'hFFFFFFFFFFFFFF, 8'hFF, 8'hFF, 16'hFFFF, 6'd5);
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_timeout"}, {31'd0, finished}, 32'd1);
    endtask

    int base, d0, e0;

    initial begin
        rx_tab[0] = 8'hAB; rx_tab[1] = 8'hCD; rx_tab[2] = 8'h00; rx_tab[3] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outs", {bm_req, bm_op, bm_tx_byte, busy, done, error, bram_wr_en,
                           bram_wr_data, bram_addr}, 32'd0);
        reset = 1'b0;

        // 1: MATCH-ROM write of three BRAM bytes
        preload(5'd0, 8'h11); preload(5'd1, 8'h22); preload(5'd2, 8'h33);
        base = op_log.size(); d0 = done_cnt; e0 = err_cnt;
        set_cmd(1'b1, 1'b1, 8'h55, 56'h00112233445566, 8'hA5, 8'h0F, 16'h1234, 6'd3);
        run_wait("t1", 0);
        chk_ops("t1", base, 16, exp1);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_err", err_cnt - e0, 0);

        // 2: SKIP-ROM read of two bytes into BRAM
        preload(5'd0, 8'h00); preload(5'd1, 8'h00);
        base = op_log.size(); d0 = done_cnt; rd_base = rd_cnt;
        set_cmd(1'b0, 1'b0, 8'hCC, 56'h0, 8'h00, 8'hF0, 16'h0010, 6'd2);
        run_wait("t2", 0);
        chk_ops("t2", base, 7, exp2);
        chk("t2_mem0", {24'd0, mem[0]}, 32'hAB);
        chk("t2_mem1", {24'd0, mem[1]}, 32'hCD);
        chk("t2_done", done_cnt - d0, 1);

        // 3: no presence; also start->first bm_req latency
        pres_cfg = 1'b0;
        base = op_log.size(); d0 = done_cnt; e0 = err_cnt;
        set_cmd(1'b0, 1'b1, 8'hCC, 56'h0, 8'h00, 8'hF0, 16'h0010, 6'd2);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t3_c1_req", {31'd0, bm_req}, 0);
        chk("t3_c1_busy", {31'd0, busy}, 1);
        @(negedge clk);
        chk("t3_c2_req", {30'd0, bm_op, bm_req}, 32'd1);
        repeat (12) @(negedge clk);
        chk("t3_busy", {31'd0, busy}, 0);
        chk("t3_nops", op_log.size() - base, 1);
        chk("t3_err", err_cnt - e0, 1);
        chk("t3_done", done_cnt - d0, 0);
        pres_cfg = 1'b1;

        // 4a: oversize length -> error one cycle after LATCH, no bus ops
        base = op_log.size(); e0 = err_cnt;
        set_cmd(1'b0, 1'b1, 8'hCC, 56'h0, 8'h00, 8'hF0, 16'h0010, 6'd33);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t4_latch_err", {31'd0, error}, 0);
        @(negedge clk);
        chk("t4_err_pulse", {31'd0, error}, 1);
        @(negedge clk);
        chk("t4_idle", {30'd0, busy, error}, 0);
        repeat (4) @(negedge clk);
        chk("t4_nops", op_log.size() - base, 0);
        chk("t4_errcnt", err_cnt - e0, 1);

        // 4b: zero-length -> header only
        base = op_log.size(); d0 = done_cnt;
        set_cmd(1'b0, 1'b0, 8'hCC, 56'h0, 8'h00, 8'hF0, 16'h0010, 6'd0);
        run_wait("t4b", 0);
        chk_ops("t4b", base, 5, exp2);
        chk("t4b_done", done_cnt - d0, 1);

        // 5: second start mid-transaction is ignored
        preload(5'd0, 8'h00); preload(5'd1, 8'h00);
        base = op_log.size(); d0 = done_cnt; rd_base = rd_cnt;
        set_cmd(1'b0, 1'b0, 8'hCC, 56'h0, 8'h00, 8'hF0, 16'h0010, 6'd2);
        run_wait("t5", 10);
        repeat (10) @(negedge clk);
        chk_ops("t5", base, 7, exp2);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_done", done_cnt - d0, 1);

        // 6: reset during the 6th header byte, then a clean run
        preload(5'd0, 8'h11); preload(5'd1, 8'h22); preload(5'd2, 8'h33);
        base = op_log.size(); d0 = done_cnt; e0 = err_cnt;
        set_cmd(1'b1, 1'b1, 8'h55, 56'h00112233445566, 8'hA5, 8'h0F, 16'h1234, 6'd3);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (op_log.size() >= base + 7) break;
        end
        chk("t6_reached", {31'd0, op_log.size() >= base + 7}, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_outs", {bm_req, bm_op, bm_tx_byte, busy, done, error, bram_wr_en,
                        bram_wr_data, bram_addr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_nops", op_log.size() - base, 7);
        chk("t6_nopulse", (done_cnt - d0) + (err_cnt - e0), 0);
        base = op_log.size(); d0 = done_cnt;
        run_wait("t6b", 0);
        chk_ops("t6b", base, 16, exp1);
        chk("t6b_done", done_cnt - d0, 1);

        chk("overlap", overlap_err, 0);
        chk("tx_stable", stable_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
